flatten_stream: RTL and testbench

Parametrised successor to the single-shot flatten stage. Collects a H×W×C int8 activation map from the last conv/pool layer over a ready/valid input stream, IN_LANES channels per beat. It then drains the flattened vector to the dense layer over a ready/valid output stream, OUT_LANES elements per beat. Back-pressure is supported on both sides, and an abort/restart is available at any time.

---
 rtl/flatten_stream_pkg.sv | 32 +++
 rtl/flatten_stream_addr_gen.sv | 33 +++
 rtl/flatten_stream.sv | 156 +++++++++++++++
 tb/tb_flatten_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flatten_stream_pkg.sv
// Shared types for the streaming flatten stage.
// Holds element type, FSM states and beat-count helpers.
package flatten_stream_pkg;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } flatten_stream_state_t;

  function automatic int beats_in(
    input int h,
    input int w,
    input int c,
    input int lanes
  );
    return (h * w * c) / lanes;
  endfunction

  function automatic int beats_out(
    input int size,
    input int lanes
  );
    return size / lanes;
  endfunction

  localparam int BEATS_IN  = beats_in(2, 2, 64, 16);
  localparam int BEATS_OUT = beats_out(2 * 2 * 64, 4);

endpackage

// File: rtl/flatten_stream_addr_gen.sv
// Maps an output beat number and lane to a buffer address.
// CHW selects channel-major order, otherwise HWC order.
module flatten_stream_addr_gen
  import flatten_stream_pkg::*;
#(
  parameter int INPUT_HEIGHT   = 2,
  parameter int INPUT_WIDTH    = 2,
  parameter int INPUT_CHANNELS = 64,
  parameter int OUT_LANES      = 4,
  parameter int IW             = 6,
  parameter int AW             = 9,
  parameter bit CHW            = 1'b0
) (
  input  logic [IW-1:0] index,
  output logic [AW-1:0] addr [OUT_LANES]
);

  localparam int HW = INPUT_HEIGHT * INPUT_WIDTH;

  logic [AW-1:0] k [OUT_LANES];

  always_comb begin
    for (int l = 0; l < OUT_LANES; l++) begin
      k[l] = AW'(index) * AW'(OUT_LANES) + AW'(l);
      if (CHW)
        addr[l] = (k[l] % AW'(HW)) * AW'(INPUT_CHANNELS)
                + k[l] / AW'(HW);
      else
        addr[l] = k[l];
    end
  end

endmodule

// File: rtl/flatten_stream.sv
// Collects an HxWxC int8 map over a stream, drains it flattened.
// FLATTEN_STREAM_CHW_EN selects channel-major output order.
module flatten_stream
  import flatten_stream_pkg::*;
#(
  parameter int INPUT_HEIGHT   = 2,
  parameter int INPUT_WIDTH    = 2,
  parameter int INPUT_CHANNELS = 64,
  parameter int IN_LANES       = 16,
  parameter int OUT_LANES      = 4,
  parameter int OUTPUT_SIZE    =
    INPUT_HEIGHT * INPUT_WIDTH * INPUT_CHANNELS,
  localparam int GROUPS = INPUT_CHANNELS / IN_LANES,
  localparam int NOUT   = beats_out(OUTPUT_SIZE, OUT_LANES),
  localparam int RW     = $clog2(INPUT_HEIGHT + 1),
  localparam int CW     = $clog2(INPUT_WIDTH + 1),
  localparam int GW     = $clog2(GROUPS + 1),
  localparam int IW     = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  int8_t [IN_LANES-1:0]      in_data,
  input  logic [RW-1:0]             in_row,
  input  logic [CW-1:0]             in_col,
  input  logic [GW-1:0]             in_cgroup,
  output logic                      out_valid,
  input  logic                      out_ready,
  output int8_t [OUT_LANES-1:0]     out_data,
  output logic [IW-1:0]             out_index,
  output logic                      out_last,
  output logic                      done,
  output logic                      coord_err
);

  localparam int NIN = beats_in(INPUT_HEIGHT, INPUT_WIDTH,
                                INPUT_CHANNELS, IN_LANES);
  localparam int AW  = $clog2(OUTPUT_SIZE) + 1;
  localparam int MW  = $clog2(OUTPUT_SIZE);
  localparam int BW  = $clog2(NIN + 1);

`ifdef FLATTEN_STREAM_CHW_EN
  localparam bit CHW = 1'b1;
`else
  localparam bit CHW = 1'b0;
`endif

  flatten_stream_state_t state, state_nx;

  logic [BW-1:0] beat_cnt;
  logic [AW-1:0] wbase;
  logic [AW-1:0] raddr [OUT_LANES];
  logic          accept;
  logic          in_range;
  logic          last_in;
  logic          last_out;

  int8_t mem [2**MW];

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == DRAIN);
  assign accept    = in_valid && in_ready && !start;
  assign last_in   = (beat_cnt == BW'(NIN - 1));
  assign last_out  = (out_index == IW'(NOUT - 1));
  assign out_last  = out_valid && last_out;

  assign in_range = (in_row < RW'(INPUT_HEIGHT))
                 && (in_col < CW'(INPUT_WIDTH))
                 && (in_cgroup < GW'(GROUPS));

  assign wbase = ((AW'(in_row) * AW'(INPUT_WIDTH) + AW'(in_col))
                 * AW'(INPUT_CHANNELS))
               + AW'(in_cgroup) * AW'(IN_LANES);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      COLLECT: if (accept && last_in) state_nx = DRAIN;
      DRAIN:   if (out_ready && last_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = COLLECT;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      out_index <= '0;
      coord_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        beat_cnt  <= '0;
        out_index <= '0;
        coord_err <= 1'b0;
      end else begin
        unique case (state)
          COLLECT: begin
            if (accept) begin
              beat_cnt <= last_in ? '0 : beat_cnt + 1'b1;
              if (!in_range) coord_err <= 1'b1;
            end
            out_index <= '0;
          end
          DRAIN: begin
            if (out_ready) begin
              if (last_out) begin
                done      <= 1'b1;
                out_index <= '0;
              end else begin
                out_index <= out_index + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Out-of-range beats still count toward the frame but never land.
  always_ff @(posedge clk) begin
    if (!reset && accept && in_range) begin
      for (int l = 0; l < IN_LANES; l++)
        mem[MW'(wbase + AW'(l))] <= in_data[l];
    end
  end

  flatten_stream_addr_gen #(
    .INPUT_HEIGHT   (INPUT_HEIGHT),
    .INPUT_WIDTH    (INPUT_WIDTH),
    .INPUT_CHANNELS (INPUT_CHANNELS),
    .OUT_LANES      (OUT_LANES),
    .IW             (IW),
    .AW             (AW),
    .CHW            (CHW)
  ) u_addr_gen (
    .index (out_index),
    .addr  (raddr)
  );

  always_comb begin
    for (int l = 0; l < OUT_LANES; l++)
      out_data[l] = out_valid ? mem[MW'(raddr[l])] : int8_t'(0);
  end

endmodule

// File: tb/tb_flatten_stream.sv
// Randomized bench for flatten_stream with a behavioural model.
// Define FLATTEN_STREAM_CHW_EN for both DUT and bench to test CHW.
module tb_flatten_stream;
  import flatten_stream_pkg::*;

  localparam int H  = 2;
  localparam int W  = 2;
  localparam int C  = 64;
  localparam int IL = 16;
  localparam int OL = 4;
  localparam int SZ = H * W * C;
  localparam int NB = SZ / IL;
  localparam int NO = SZ / OL;
  localparam int G  = C / IL;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  int8_t [IL-1:0]   in_data;
  logic [1:0]       in_row;
  logic [1:0]       in_col;
  logic [2:0]       in_cgroup;
  logic             out_valid;
  logic             out_ready;
  int8_t [OL-1:0]   out_data;
  logic [5:0]       out_index;
  logic             out_last;
  logic             done;
  logic             coord_err;

  flatten_stream dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_cgroup (in_cgroup),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done),
    .coord_err (coord_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  byte         mdl [SZ];
  logic [31:0] obs [NO];
  int          exp_idx = 0;
  bit          exp_done = 1'b0;
  bit          stalled_prev = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] prev_data = '0;
  logic [5:0]  prev_index = '0;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Flattened element k comes from this HWC buffer address.
  function automatic int src_addr(input int k);
`ifdef FLATTEN_STREAM_CHW_EN
    return (k % (H * W)) * C + k / (H * W);
`else
    return k;
`endif
  endfunction

  function automatic logic [31:0] exp_beat(input int i);
    logic [31:0] r;
    for (int l = 0; l < OL; l++)
      r[l*8 +: 8] = mdl[src_addr(i * OL + l)];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [31:0] od;
    od = out_data;
    if (chk_en) begin
      check("done", done, exp_done);
      if (out_valid) begin
        check("out_index", out_index, exp_idx);
        check("out_last", out_last, exp_idx == NO - 1);
        check("out_data", od, exp_beat(exp_idx));
        if (stalled_prev) begin
          check("stall_data", od, prev_data);
          check("stall_index", out_index, prev_index);
        end
        obs[exp_idx] = od;
      end
    end
    stalled_prev = out_valid && !out_ready;
    prev_data    = od;
    prev_index   = out_index;
    exp_done = out_valid && out_ready && (exp_idx == NO - 1)
            && !start && !reset;
    if (reset || start)             exp_idx = 0;
    else if (out_valid && out_ready) exp_idx++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_beat);
    start = 1'b1;
    if (with_beat) begin
      in_valid  = 1'b1;
      in_row    = 2'd0;
      in_col    = 2'd0;
      in_cgroup = 3'd0;
      for (int l = 0; l < IL; l++) in_data[l] = int8_t'($urandom);
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("start_in_ready", in_ready, 1'b1);
  endtask

  task automatic feed(input int order, input bit adata,
                      input int badi, input int nb, input bit gaps);
    int perm [NB];
    for (int i = 0; i < NB; i++)
      perm[i] = (order == 1) ? NB - 1 - i : i;
    if (order == 2) begin
      for (int i = NB - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
    end
    for (int i = 0; i < nb; i++) begin
      int p, pos, r, c, g;
      p   = perm[i];
      pos = p / G;
      r   = pos / W;
      c   = pos % W;
      g   = (i == badi) ? G : p % G;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      check("pre_valid", out_valid, 1'b0);
      in_row    = 2'(r);
      in_col    = 2'(c);
      in_cgroup = 3'(g);
      for (int l = 0; l < IL; l++)
        in_data[l] = adata ? int8_t'((pos * C + g * IL + l) & 255)
                           : int8_t'($urandom);
      in_valid = 1'b1;
      if (in_ready && g < G)
        for (int l = 0; l < IL; l++)
          mdl[pos * C + g * IL + l] = in_data[l];
      tick();
      in_valid = 1'b0;
    end
    if (nb == NB) check("valid_t1", out_valid, 1'b1);
  endtask

  task automatic drain(input int mode, input bit exp_err,
                       input bit time_chk);
    int n;
    bit seen;
    logic [3:0] pat;
    n    = 0;
    seen = 1'b0;
    pat  = 4'b1001;
    check("coord_err", coord_err, exp_err);
    out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!seen && n < 500) begin
      tick();
      n++;
      if (done) seen = 1'b1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[n % 4];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
    check("drain_timeout", seen, 1'b1);
    if (time_chk) check("drain_cycles", n, NO);
    tick();
    check("done_pulse", done, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_coord_err"}, coord_err, 1'b0);
    check({tag, "_out_index"}, out_index, 6'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_row    = '0;
    in_col    = '0;
    in_cgroup = '0;
    for (int i = 0; i < SZ; i++) mdl[i] = 0;
    repeat (3) tick();
    check_reset_vals("rst");
    chk_en = 1'b1;
    reset  = 1'b0;
    tick();

    pulse_start(1'b0);
    feed(0, 1'b1, -1, NB, 1'b0);
    drain(0, 1'b0, 1'b1);
`ifdef FLATTEN_STREAM_CHW_EN
    check("lit_chw_beat0", obs[0], 32'hC0804000);
`else
    check("lit_hwc_beat5", obs[5], 32'h17161514);
    check("lit_hwc_beat63", obs[63], 32'hFFFEFDFC);
`endif

    pulse_start(1'b0);
    feed(1, 1'b1, -1, NB, 1'b1);
    drain(0, 1'b0, 1'b1);
`ifndef FLATTEN_STREAM_CHW_EN
    check("rev_hwc_beat5", obs[5], 32'h17161514);
`endif

    pulse_start(1'b0);
    feed(2, 1'b0, -1, NB, 1'b1);
    drain(1, 1'b0, 1'b0);

    pulse_start(1'b0);
    feed(2, 1'b0, $urandom_range(0, NB - 1), NB, 1'b1);
    drain(2, 1'b1, 1'b0);

    pulse_start(1'b0);
    feed(2, 1'b0, -1, 7, 1'b1);
    pulse_start(1'b1);
    feed(2, 1'b0, -1, NB, 1'b1);
    drain(2, 1'b0, 1'b0);

    pulse_start(1'b0);
    feed(0, 1'b0, -1, NB, 1'b0);
    out_ready = 1'b1;
    repeat (NO - 1) tick();
    check("pre_abort_last", out_last, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_no_done", done, 1'b0);
    check("abort_collect", in_ready, 1'b1);
    feed(2, 1'b0, -1, NB, 1'b0);
    drain(0, 1'b0, 1'b1);

    pulse_start(1'b0);
    feed(2, 1'b0, 3, NB, 1'b1);
    check("err_before_rst", coord_err, 1'b1);
    out_ready = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    tick();
    check("idle_after_rst", in_ready, 1'b0);

    pulse_start(1'b0);
    feed(2, 1'b0, -1, NB, 1'b1);
    drain(2, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
